// File: rtl/imm_extend_pipe_pkg.sv
// Shared decode constants for the immediate-generation unit: field widths,
// the jump PC split point, and the extension mode encodings.
package imm_extend_pipe_pkg;

   localparam int IMM_BITS  = 16;
   localparam int JBITS     = 26;
   localparam int JPC_SPLIT = 28;

   localparam logic [2:0] MODE_SIGN   = 3'b000;
   localparam logic [2:0] MODE_ZERO   = 3'b001;
   localparam logic [2:0] MODE_UPPER  = 3'b010;
   localparam logic [2:0] MODE_BRANCH = 3'b011;
   localparam logic [2:0] MODE_JUMP   = 3'b100;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: maps (instr field, pc, mode) to an
// NBITS operand plus an illegal-mode flag.
module imm_extend_core
   import imm_extend_pipe_pkg::*;
#(
   parameter int NBITS = 32
) (
   input  logic [JBITS-1:0] i_instr,
   input  logic [NBITS-1:0] i_pc,
   input  logic [2:0]       i_mode,
   output logic [NBITS-1:0] result,
   output logic             illegal
);

   logic [IMM_BITS-1:0] imm;
   logic [NBITS-1:0]    sext;
   logic                unused_pc_low;

   assign imm  = i_instr[IMM_BITS-1:0];
   assign sext = {{(NBITS-IMM_BITS){imm[IMM_BITS-1]}}, imm};

   // Only the PC region bits above the jump field take part in jump targets.
   assign unused_pc_low = ^i_pc[JPC_SPLIT-1:0];

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (i_mode)
         MODE_SIGN:   result = sext;
         MODE_ZERO:   result = {{(NBITS-IMM_BITS){1'b0}}, imm};
         MODE_UPPER:  result = {imm, {(NBITS-IMM_BITS){1'b0}}};
         MODE_BRANCH: result = {sext[NBITS-3:0], 2'b00};
         MODE_JUMP:   result = {i_pc[NBITS-1:JPC_SPLIT], i_instr, 2'b00};
         default:     illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-generation stage with valid/ready handshake and flush.
// Define IMM_SKID_EN to add a skid register so o_ready is fully registered.
module imm_extend_pipe
   import imm_extend_pipe_pkg::*;
#(
   parameter int NBITS = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [JBITS-1:0] i_instr,
   input  logic [NBITS-1:0] i_pc,
   input  logic [2:0]       i_mode,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [NBITS-1:0] o_result,
   output logic             o_illegal
);

   logic [NBITS-1:0] core_result;
   logic             core_illegal;
   logic             take_in;

   imm_extend_core #(.NBITS(NBITS)) u_core (
      .i_instr (i_instr),
      .i_pc    (i_pc),
      .i_mode  (i_mode),
      .result  (core_result),
      .illegal (core_illegal)
   );

   assign take_in = i_valid && o_ready;

`ifdef IMM_SKID_EN
   logic             skid_valid;
   logic [NBITS-1:0] skid_result;
   logic             skid_illegal;

   assign o_ready = !skid_valid;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_valid      <= 1'b0;
         o_result     <= '0;
         o_illegal    <= 1'b0;
         skid_valid   <= 1'b0;
         skid_result  <= '0;
         skid_illegal <= 1'b0;
      end else if (i_flush) begin
         o_valid    <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!o_valid || i_ready) begin
         // Output slot frees up: the skid entry is older, so it goes first.
         if (skid_valid) begin
            o_result   <= skid_result;
            o_illegal  <= skid_illegal;
            o_valid    <= 1'b1;
            skid_valid <= 1'b0;
         end else if (take_in) begin
            o_result  <= core_result;
            o_illegal <= core_illegal;
            o_valid   <= 1'b1;
         end else begin
            o_valid <= 1'b0;
         end
      end else if (take_in) begin
         skid_result  <= core_result;
         skid_illegal <= core_illegal;
         skid_valid   <= 1'b1;
      end
   end
`else
   logic take_out;

   assign o_ready  = !o_valid || i_ready;
   assign take_out = o_valid && i_ready;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_valid   <= 1'b0;
         o_result  <= '0;
         o_illegal <= 1'b0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (take_in) begin
         o_result  <= core_result;
         o_illegal <= core_illegal;
         o_valid   <= 1'b1;
      end else if (take_out) begin
         o_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed vectors, stall/flush/reset
// sequences and randomized traffic against a queue-based reference model.
module tb_imm_extend_pipe;

   logic        clk;
   logic        i_reset, i_flush, i_valid, i_ready;
   logic        o_ready, o_valid, o_illegal;
   logic [25:0] i_instr;
   logic [31:0] i_pc, o_result;
   logic [2:0]  i_mode;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] res;
      logic        ill;
   } ent_t;

   typedef struct {
      logic [2:0]  mode;
      logic [25:0] instr;
      logic [31:0] pc;
      logic [31:0] exp_res;
      logic        exp_ill;
   } vec_t;

   ent_t q[$];

   imm_extend_pipe #(.NBITS(32)) dut (
      .i_clk     (clk),
      .i_reset   (i_reset),
      .i_flush   (i_flush),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_instr   (i_instr),
      .i_pc      (i_pc),
      .i_mode    (i_mode),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_result  (o_result),
      .o_illegal (o_illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ent_t ref_ext(input logic [2:0] m, input logic [25:0] ins,
                                    input logic [31:0] pc);
      ent_t e;
      int   sx;
      logic [31:0] zx;
      sx    = int'($signed(ins[15:0]));
      zx    = 32'(ins[15:0]);
      e.ill = 1'b0;
      case (m)
         3'd0:    e.res = sx;
         3'd1:    e.res = zx;
         3'd2:    e.res = zx * 32'h0001_0000;
         3'd3:    e.res = sx * 4;
         3'd4:    e.res = (pc & 32'hF000_0000) | (32'(ins) * 4);
         default: begin e.res = 32'd0; e.ill = 1'b1; end
      endcase
      return e;
   endfunction

   function automatic logic model_ready(input logic rdy);
`ifdef IMM_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || rdy;
`endif
   endfunction

   // One cycle: drive at posedge+1, check at negedge, advance model at the edge.
   task automatic step(input logic v, input logic rdy, input logic fl, input logic [2:0] m,
                       input logic [25:0] ins, input logic [31:0] pc);
      logic mready;
      i_valid = v; i_ready = rdy; i_flush = fl; i_mode = m; i_instr = ins; i_pc = pc;
      #4;
      mready = model_ready(rdy);
      chk("valid", 32'(o_valid), 32'(q.size() > 0));
      chk("ready", 32'(o_ready), 32'(mready));
      if (q.size() > 0) begin
         chk("result", o_result, q[0].res);
         chk("illegal", 32'(o_illegal), 32'(q[0].ill));
      end
      if (fl) q.delete();
      else begin
         if (q.size() > 0 && rdy) void'(q.pop_front());
         if (v && mready) q.push_back(ref_ext(m, ins, pc));
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[6];

   initial begin
      tbl[0] = '{3'd1, 26'h0008001, 32'h0, 32'h0000_8001, 1'b0};
      tbl[1] = '{3'd2, 26'h0008001, 32'h0, 32'h8001_0000, 1'b0};
      tbl[2] = '{3'd3, 26'h0008001, 32'h0, 32'hFFFE_0004, 1'b0};
      tbl[3] = '{3'd4, 26'h0000010, 32'hA000_0040, 32'hA000_0040, 1'b0};
      tbl[4] = '{3'd6, 26'h0008001, 32'h0, 32'h0000_0000, 1'b1};
      tbl[5] = '{3'd0, 26'h0008001, 32'h0, 32'hFFFF_8001, 1'b0};

      i_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      i_instr = '0; i_pc = '0; i_mode = '0;
      #1 i_reset = 1'b1;
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_result", o_result, 32'd0);
      chk("rst_illegal", 32'(o_illegal), 32'd0);
      @(posedge clk);
      #1 i_reset = 1'b0;
      #1 chk("rst_ready", 32'(o_ready), 32'd1);

      // First accept: sign mode, one-cycle latency, single-cycle valid pulse
      i_valid = 1'b1; i_mode = 3'd0; i_instr = 26'h0008001; i_ready = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk("first_valid", 32'(o_valid), 32'd1);
      chk("first_result", o_result, 32'hFFFF_8001);
      @(posedge clk); #1;
      chk("first_pulse_end", 32'(o_valid), 32'd0);

      // Back-to-back table, no bubbles
      for (int i = 0; i < 6; i++) begin
         i_valid = 1'b1; i_mode = tbl[i].mode; i_instr = tbl[i].instr; i_pc = tbl[i].pc;
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'd1);
         chk($sformatf("tbl%0d_result", i), o_result, tbl[i].exp_res);
         chk($sformatf("tbl%0d_illegal", i), 32'(o_illegal), 32'(tbl[i].exp_ill));
      end
      i_valid = 1'b0;
      @(posedge clk); #1;
      chk("tbl_drain", 32'(o_valid), 32'd0);

      // Stall for 3 cycles while two instructions stream in
      begin
         int idx;
         logic [25:0] ins_list [2];
         logic v, rdy, acc;
         ins_list[0] = 26'h0001234;
         ins_list[1] = 26'h0008001;
         idx = 0;
         for (int c = 0; c < 8; c++) begin
            rdy = (c >= 4);
            v   = (idx < 2);
            acc = v && model_ready(rdy);
            step(v, rdy, 1'b0, (idx == 0) ? 3'd1 : 3'd0, ins_list[idx % 2], 32'h0);
            if (acc) idx++;
         end
         chk("stall_sent", 32'(idx), 32'd2);
         chk("stall_drained", 32'(q.size()), 32'd0);
      end

      // Flush while stalled and full, with a new input in the flush cycle
      step(1'b1, 1'b0, 1'b0, 3'd2, 26'h00000AA, 32'h0);
      step(1'b1, 1'b0, 1'b0, 3'd3, 26'h00000BB, 32'h0);
      step(1'b1, 1'b0, 1'b1, 3'd0, 26'h00000CC, 32'h0);
      for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b0, 3'd0, 26'h0, 32'h0);

      // Async reset mid-stall
      step(1'b1, 1'b0, 1'b0, 3'd0, 26'h0000777, 32'h0);
      step(1'b0, 1'b0, 1'b0, 3'd0, 26'h0, 32'h0);
      i_reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(o_valid), 32'd0);
      chk("async_rst_ready", 32'(o_ready), 32'd1);
      q.delete();
      #2 i_reset = 1'b0;
      @(posedge clk); #1;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0,
              3'($urandom % 8), 26'($urandom), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
